// File: rtl/fsm_step_n.sv
// Two-button step selector: qualified up/down commands move a bounded or cyclic position register.
// Optional registered one-hot decode of the position when FSM_STEP_ONEHOT_EN is defined.
module fsm_step_n #(
    parameter int N_STATES = 4,
    parameter int W        = 2,
    parameter int WRAP     = 1,
    parameter int HOLD_CYC = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                inA,
    input  logic                inB,
    output logic [W-1:0]        out_state,
    output logic                out_edge,
    output logic                out_err
`ifdef FSM_STEP_ONEHOT_EN
    ,
    output logic [N_STATES-1:0] out_onehot
`endif
);

    localparam logic [1:0]   CMD_IDLE = 2'b00;
    localparam logic [1:0]   CMD_UP   = 2'b10;
    localparam logic [1:0]   CMD_DN   = 2'b01;
    localparam logic [W-1:0] S_ZERO   = '0;
    localparam logic [W-1:0] S_ONE    = W'(1);
    localparam logic [W-1:0] S_MAX    = W'(N_STATES - 1);
    localparam logic [W:0]   S_LIMIT  = (W+1)'(N_STATES);
    localparam logic [8:0]   HOLD     = 9'(HOLD_CYC);

    generate
        if (N_STATES < 2 || N_STATES > 16 || (1 << W) < N_STATES ||
            HOLD_CYC < 1 || HOLD_CYC > 255 || WRAP < 0 || WRAP > 1) begin : g_bad_cfg
            $error("fsm_step_n: illegal parameter combination");
        end
    endgenerate

    logic [W-1:0] state;
    logic [W-1:0] state_nxt;
    logic [7:0]   qcnt;
    logic [7:0]   qcnt_nxt;
    logic [1:0]   prev_cmd;
    logic [1:0]   cmd;
    logic [1:0]   cmd_q;
    logic         active;
    logic [8:0]   run_len;
    logic         step;
    logic         edge_nxt;
    logic         err_nxt;

    // Qualification: run_len is the length of the current run including this edge.
    always_comb begin
        cmd     = en ? {inA, inB} : CMD_IDLE;
        active  = (cmd == CMD_UP) || (cmd == CMD_DN);
        cmd_q   = active ? cmd : CMD_IDLE;
        run_len = '0;
        if (active) begin
            if (cmd == prev_cmd) run_len = {1'b0, qcnt} + 9'd1;
            else                 run_len = 9'd1;
        end
        step     = active && (run_len >= HOLD);
        qcnt_nxt = step ? 8'd0 : run_len[7:0];
        err_nxt  = en && inA && inB;
    end

    always_comb begin
        state_nxt = state;
        edge_nxt  = 1'b0;
        if ({1'b0, state} >= S_LIMIT) begin
            // Unreachable encoding: recover to a legal state.
            state_nxt = S_ZERO;
        end else if (step && cmd == CMD_UP) begin
            if (state == S_MAX) begin
                edge_nxt  = 1'b1;
                state_nxt = (WRAP != 0) ? S_ZERO : S_MAX;
            end else begin
                state_nxt = state + S_ONE;
            end
        end else if (step && cmd == CMD_DN) begin
            if (state == S_ZERO) begin
                edge_nxt  = 1'b1;
                state_nxt = (WRAP != 0) ? S_MAX : S_ZERO;
            end else begin
                state_nxt = state - S_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_ZERO;
            qcnt     <= 8'd0;
            prev_cmd <= CMD_IDLE;
            out_edge <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            qcnt     <= qcnt_nxt;
            prev_cmd <= cmd_q;
            out_edge <= edge_nxt;
            out_err  <= err_nxt;
        end
    end

    assign out_state = state;

`ifdef FSM_STEP_ONEHOT_EN
    logic [N_STATES-1:0] onehot_nxt;

    always_comb begin
        onehot_nxt = '0;
        for (int i = 0; i < N_STATES; i++)
            onehot_nxt[i] = ({1'b0, state_nxt} == (W+1)'(i));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out_onehot <= N_STATES'(1);
        else          out_onehot <= onehot_nxt;
    end
`endif

endmodule

// File: tb/tb_fsm_step_n.sv
// Directed bench for fsm_step_n: wrap, saturate, qualification, conflict/enable, async reset.
// Four instances share the stimulus; each scenario checks the instance it targets.
module tb_fsm_step_n;

    logic clk;
    logic reset_n;
    logic en;
    logic inA;
    logic inB;

    logic [1:0] st_w;
    logic [2:0] st_s;
    logic [1:0] st_q;
    logic [2:0] st_o;
    logic       edg_w, edg_s, edg_q, edg_o;
    logic       err_w, err_s, err_q, err_o;
`ifdef FSM_STEP_ONEHOT_EN
    logic [3:0] oh_w;
    logic [4:0] oh_s;
    logic [3:0] oh_q;
    logic [5:0] oh_o;
`endif

    int checks = 0;
    int errors = 0;

    fsm_step_n #(.N_STATES(4), .W(2), .WRAP(1), .HOLD_CYC(1)) u_wrap (
        .clk(clk), .reset_n(reset_n), .en(en), .inA(inA), .inB(inB),
        .out_state(st_w), .out_edge(edg_w), .out_err(err_w)
`ifdef FSM_STEP_ONEHOT_EN
        , .out_onehot(oh_w)
`endif
    );

    fsm_step_n #(.N_STATES(5), .W(3), .WRAP(0), .HOLD_CYC(1)) u_sat (
        .clk(clk), .reset_n(reset_n), .en(en), .inA(inA), .inB(inB),
        .out_state(st_s), .out_edge(edg_s), .out_err(err_s)
`ifdef FSM_STEP_ONEHOT_EN
        , .out_onehot(oh_s)
`endif
    );

    fsm_step_n #(.N_STATES(4), .W(2), .WRAP(1), .HOLD_CYC(3)) u_qual (
        .clk(clk), .reset_n(reset_n), .en(en), .inA(inA), .inB(inB),
        .out_state(st_q), .out_edge(edg_q), .out_err(err_q)
`ifdef FSM_STEP_ONEHOT_EN
        , .out_onehot(oh_q)
`endif
    );

    fsm_step_n #(.N_STATES(6), .W(3), .WRAP(1), .HOLD_CYC(1)) u_oh (
        .clk(clk), .reset_n(reset_n), .en(en), .inA(inA), .inB(inB),
        .out_state(st_o), .out_edge(edg_o), .out_err(err_o)
`ifdef FSM_STEP_ONEHOT_EN
        , .out_onehot(oh_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic e, input logic a, input logic b);
        en  = e;
        inA = a;
        inB = b;
    endtask

    // Called 1 time unit after an edge; reset pulse stays clear of the next edge.
    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    int exp_w_up [5] = '{1, 2, 3, 0, 1};
    int exp_w_ue [5] = '{0, 0, 0, 1, 0};
    int exp_s_st [6] = '{1, 2, 3, 4, 4, 4};
    int exp_s_ed [6] = '{0, 0, 0, 0, 1, 1};
    int exp_q_a7 [7] = '{0, 0, 1, 1, 1, 2, 2};
    int exp_q_ab [5] = '{2, 2, 2, 2, 1};

    initial begin
        reset_n = 1'b0;
        drv(1'b1, 1'b1, 1'b0);
        #3;
        chk("rst_state", 32'(st_w), 32'd0);
        chk("rst_edge", 32'(edg_w), 32'd0);
        chk("rst_err", 32'(err_w), 32'd0);
`ifdef FSM_STEP_ONEHOT_EN
        chk("rst_oh_w", 32'(oh_w), 32'h1);
        chk("rst_oh_s", 32'(oh_s), 32'h1);
        chk("rst_oh_q", 32'(oh_q), 32'h1);
        chk("rst_oh_o", 32'(oh_o), 32'h1);
`endif
        #1 reset_n = 1'b1;

        // Wrap, HOLD_CYC=1: up five edges, then down two.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("wrap_up_st%0d", i), 32'(st_w), 32'(exp_w_up[i]));
            chk($sformatf("wrap_up_ed%0d", i), 32'(edg_w), 32'(exp_w_ue[i]));
        end
        drv(1'b1, 1'b0, 1'b1);
        tick();
        chk("wrap_dn_st0", 32'(st_w), 32'd0);
        chk("wrap_dn_ed0", 32'(edg_w), 32'd0);
        tick();
        chk("wrap_dn_st1", 32'(st_w), 32'd3);
        chk("wrap_dn_ed1", 32'(edg_w), 32'd1);
        chk("qual_pre_rst", 32'(st_q), 32'd1);

        // Async reset mid-run, clear of any clock edge; inB stays held.
        #2 reset_n = 1'b0;
        #1;
        chk("arst_st_w", 32'(st_w), 32'd0);
        chk("arst_ed_w", 32'(edg_w), 32'd0);
        chk("arst_st_q", 32'(st_q), 32'd0);
        #1 reset_n = 1'b1;
        tick();
        chk("rel_st_w", 32'(st_w), 32'd3);
        chk("rel_q_e1", 32'(st_q), 32'd0);
        tick();
        chk("rel_q_e2", 32'(st_q), 32'd0);
        tick();
        chk("rel_q_e3", 32'(st_q), 32'd3);
        chk("rel_q_ed", 32'(edg_q), 32'd1);
        drv(1'b1, 1'b0, 1'b0);
        tick();
        chk("rel_q_ed_off", 32'(edg_q), 32'd0);

        // Saturate, N_STATES=5.
        pulse_reset();
        drv(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("sat_st%0d", i), 32'(st_s), 32'(exp_s_st[i]));
            chk($sformatf("sat_ed%0d", i), 32'(edg_s), 32'(exp_s_ed[i]));
        end
        drv(1'b1, 1'b0, 1'b1);
        tick();
        chk("sat_dn_st", 32'(st_s), 32'd3);
        chk("sat_dn_ed", 32'(edg_s), 32'd0);

        // Qualification, HOLD_CYC=3.
        pulse_reset();
        drv(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("qual_a7_%0d", i), 32'(st_q), 32'(exp_q_a7[i]));
        end
        drv(1'b1, 1'b0, 1'b0);
        tick();
        chk("qual_idle", 32'(st_q), 32'd2);
        for (int i = 0; i < 5; i++) begin
            if (i < 2) drv(1'b1, 1'b1, 1'b0);
            else       drv(1'b1, 1'b0, 1'b1);
            tick();
            chk($sformatf("qual_ab_%0d", i), 32'(st_q), 32'(exp_q_ab[i]));
        end
        drv(1'b0, 1'b0, 1'b1);
        tick();
        drv(1'b1, 1'b0, 1'b1);
        tick();
        tick();
        chk("qual_en_restart", 32'(st_q), 32'd1);
        tick();
        chk("qual_en_step", 32'(st_q), 32'd0);

        // Conflict and enable.
        pulse_reset();
        drv(1'b1, 1'b1, 1'b1);
        tick();
        chk("cfl_err0", 32'(err_w), 32'd1);
        chk("cfl_st0", 32'(st_w), 32'd0);
        tick();
        chk("cfl_err1", 32'(err_w), 32'd1);
        chk("cfl_st1", 32'(st_w), 32'd0);
        drv(1'b1, 1'b0, 1'b0);
        tick();
        chk("cfl_err_off", 32'(err_w), 32'd0);
        drv(1'b0, 1'b1, 1'b0);
        tick();
        tick();
        chk("en0_st", 32'(st_w), 32'd0);
        drv(1'b0, 1'b1, 1'b1);
        tick();
        chk("en0_err", 32'(err_w), 32'd0);
        drv(1'b1, 1'b1, 1'b0);
        tick();
        chk("en1_st", 32'(st_w), 32'd1);

        // Six-state sweep; one-hot decode checked when present.
        pulse_reset();
        drv(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("oh_st%0d", i), 32'(st_o), 32'((i + 1) % 6));
`ifdef FSM_STEP_ONEHOT_EN
            chk($sformatf("oh_vec%0d", i), 32'(oh_o), 32'(1) << ((i + 1) % 6));
`endif
        end
        chk("oh_edge", 32'(edg_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
